// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the byte-memory port
// that the arbiter serves.
//   slave  - arbiter side: takes requests and mem_rdata, drives acks, read data and memory controls.
//   master - core/memory side: the mirror image.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8
) ();
  // Fetch port
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_ack;
  logic [31:0]       f_ope;
  // Data port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  // Byte memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_ope, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, f_ope, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory port between the fetch unit and the
// data/stack unit. A grant becomes four consecutive byte accesses. Fetches assemble a
// big-endian word, and data loads and stores are little-endian.
// Ports:
//   i_clk   - clock; all state changes on the rising edge.
//   i_reset - asynchronous, active-high reset.
//   io_bus  - fetch/data request ports and the byte memory port (slave modport).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  mem_port_arbiter_if.slave     io_bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StAck} state_e;

  state_e            r_state, w_state_d;
  logic [1:0]        r_cnt, w_cnt_d;
  logic              r_owner;       // 1 = data unit, 0 = fetch unit
  logic              r_last_owner;
  logic [ADDR_W-1:0] r_base;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [31:0]       r_f_ope;
  logic [31:0]       r_d_rdata;

  logic              w_grant_f, w_grant_d;
  logic [4:0]        w_lane;
  logic [31:0]       w_buf_d;
  logic              w_unused;

  // Address bits above the memory width are ignored by design.
  assign w_unused = ^{io_bus.f_addr[31:ADDR_W], io_bus.d_addr[31:ADDR_W]};

  // On a tie, the requester that did not win last time is granted.
  always_comb begin
    w_grant_d = io_bus.d_req && (!io_bus.f_req || !r_last_owner);
    w_grant_f = io_bus.f_req && !w_grant_d;
  end

  // Fetch fills MSB first (byte cnt -> lane 3-cnt), and data fills LSB first (lane cnt).
  always_comb begin
    w_lane  = r_owner ? {r_cnt, 3'b000} : {~r_cnt, 3'b000};
    w_buf_d = r_buf;
    w_buf_d[w_lane +: 8] = io_bus.mem_rdata;
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_grant_f || w_grant_d) begin
          w_state_d = StXfer;
          w_cnt_d   = 2'd0;
        end
      end
      StXfer: begin
        w_cnt_d = r_cnt + 2'd1;
        if (r_cnt == 2'd3) w_state_d = StAck;
      end
      StAck:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    io_bus.mem_addr  = '0;
    io_bus.mem_we    = 1'b0;
    io_bus.mem_wdata = 8'h00;
    if (r_state == StXfer) begin
      io_bus.mem_addr = r_base + ADDR_W'(r_cnt);
      io_bus.mem_we   = r_we;
      if (r_we) io_bus.mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
    end
    io_bus.busy    = (r_state != StIdle);
    io_bus.f_ack   = (r_state == StAck) && !r_owner;
    io_bus.d_ack   = (r_state == StAck) && r_owner;
    io_bus.f_ope   = r_f_ope;
    io_bus.d_rdata = r_d_rdata;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= 2'd0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b0;  // fetch, so data wins the first tie
      r_base       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= 32'h0;
      r_buf        <= 32'h0;
      r_f_ope      <= 32'h0;
      r_d_rdata    <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (r_state == StIdle && (w_grant_f || w_grant_d)) begin
        r_owner      <= w_grant_d;
        r_last_owner <= w_grant_d;
        r_base       <= w_grant_d ? io_bus.d_addr[ADDR_W-1:0] : io_bus.f_addr[ADDR_W-1:0];
        r_we         <= w_grant_d && io_bus.d_we;
        r_wdata      <= io_bus.d_wdata;
      end
      if (r_state == StXfer) begin
        r_buf <= w_buf_d;
        // Final byte: publish the whole word as the ACK state is entered. Stores leave it alone.
        if (r_cnt == 2'd3 && !r_we) begin
          if (r_owner) r_d_rdata <= w_buf_d;
          else         r_f_ope   <= w_buf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = 32'h0;

  // Byte memory model with a bench-side preload port.
  logic [7:0] mem [256];
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'h00;
  logic [7:0] poke_data = 8'h00;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clk) begin
    if (bus.f_ack || bus.d_ack) begin
      checks++;
      if (bus.f_ack && bus.d_ack) begin
        errors++;
        $display("FAIL ack_overlap: f_ack=1 d_ack=1, required only one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: f_ack=%0b d_ack=%0b, required none", bus.f_ack, bus.d_ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.d_ack !== e.is_d) begin
          errors++;
          $display("FAIL ack_order: got d_ack=%0b, required d_ack=%0b", bus.d_ack, e.is_d);
        end else begin
          checks++;
          if (e.is_d && bus.d_rdata !== e.data) begin
            errors++;
            $display("FAIL d_rdata: got %h, required %h", bus.d_rdata, e.data);
          end else if (!e.is_d && bus.f_ope !== e.data) begin
            errors++;
            $display("FAIL f_ope: got %h, required %h", bus.f_ope, e.data);
          end
        end
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  function automatic logic [31:0] fetch_word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  function automatic logic [31:0] load_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  // Drives one request, queues its expected result and waits (bounded) for the ack.
  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    exp_t e;
    bit   done;
    e.is_d = is_d;
    if (!is_d) e.data = fetch_word(addr[7:0]);
    else if (!we) begin
      e.data = load_word(addr[7:0]);
      model_rdata = e.data;
    end else e.data = model_rdata;
    exp_q.push_back(e);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.f_req = 1'b1; bus.f_addr = addr;
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if ((is_d && bus.d_ack) || (!is_d && bus.f_ack)) done = 1'b1;
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL txn_timeout: no ack for addr %h, required ack within 20 cycles", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    #1;
    checks++;
    if ({bus.f_ack, bus.d_ack, bus.mem_we, bus.busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: f_ack,d_ack,mem_we,busy=%b, required 0000",
               {bus.f_ack, bus.d_ack, bus.mem_we, bus.busy});
    end
    checks++;
    if ({bus.f_ope, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 80'h0) begin
      errors++;
      $display("FAIL reset_data: f_ope=%h d_rdata=%h mem_addr=%h mem_wdata=%h, required 0",
               bus.f_ope, bus.d_rdata, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_contention();
    logic [31:0] fw, dw;
    int          ack_i[4];
    int          n;
    exp_t        e;
    poke(8'h40, 8'hA1); poke(8'h41, 8'hA2); poke(8'h42, 8'hA3); poke(8'h43, 8'hA4);
    poke(8'h50, 8'hB1); poke(8'h51, 8'hB2); poke(8'h52, 8'hB3); poke(8'h53, 8'hB4);
    fw = 32'hA1A2A3A4;
    dw = 32'hB4B3B2B1;
    rst = 1'b1;
    model_rdata = 32'h0;
    bus.f_req = 1'b1; bus.f_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h50;
    for (int k = 0; k < 4; k++) begin
      e.is_d = (k % 2 == 0);
      e.data = e.is_d ? dw : fw;
      exp_q.push_back(e);
    end
    model_rdata = dw;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      @(posedge clk); #1;
      if (bus.f_ack || bus.d_ack) begin
        ack_i[n] = i;
        n++;
        if (n == 4) begin
          bus.f_req = 1'b0;
          bus.d_req = 1'b0;
        end
      end
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL contention_count: got %0d acks, required 4", n);
    end else begin
      checks++;
      if (ack_i[0] != 5) begin
        errors++;
        $display("FAIL contention_latency: first ack after %0d edges, required 5", ack_i[0]);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (ack_i[k] - ack_i[k-1] != 6) begin
          errors++;
          $display("FAIL contention_spacing: ack %0d gap %0d, required 6", k,
                   ack_i[k] - ack_i[k-1]);
        end
      end
    end
  endtask

  task automatic test_fetch();
    int         busy_cnt;
    int         ack_at;
    logic [7:0] exp_addr;
    exp_t       e;
    poke(8'h0B, 8'h55); poke(8'h0C, 8'h89); poke(8'h0D, 8'hE5); poke(8'h0E, 8'h6A);
    e.is_d = 1'b0;
    e.data = 32'h5589E56A;
    exp_q.push_back(e);
    bus.f_addr = 32'h0000000B;
    bus.f_req  = 1'b1;
    busy_cnt = 0;
    ack_at   = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.f_ack) begin
        if (ack_at < 0) ack_at = i;
        bus.f_req = 1'b0;
      end
      if (i <= 4) begin
        exp_addr = 8'h0B + 8'(i - 1);
        checks++;
        if (bus.mem_addr !== exp_addr || bus.mem_we !== 1'b0) begin
          errors++;
          $display("FAIL fetch_addr: cycle %0d mem_addr=%h we=%b, required %h we=0", i,
                   bus.mem_addr, bus.mem_we, exp_addr);
        end
      end
    end
    checks++;
    if (ack_at != 5) begin
      errors++;
      $display("FAIL fetch_latency: ack after %0d edges, required 5", ack_at);
    end
    checks++;
    if (busy_cnt != 5) begin
      errors++;
      $display("FAIL fetch_busy: busy for %0d cycles, required 5", busy_cnt);
    end
    checks++;
    if (bus.f_ope !== 32'h5589E56A) begin
      errors++;
      $display("FAIL fetch_hold: f_ope=%h, required 5589e56a", bus.f_ope);
    end
  endtask

  task automatic test_store_load();
    logic [7:0] exp_b[4];
    exp_b = '{8'h0A, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) poke(8'hF0 + 8'(k), 8'hFF);
    run_txn(1'b1, 1'b1, 32'h000000F0, 32'h0000000A);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[8'hF0 + 8'(k)] !== exp_b[k]) begin
        errors++;
        $display("FAIL store_bytes: mem[%h]=%h, required %h", 8'hF0 + 8'(k),
                 mem[8'hF0 + 8'(k)], exp_b[k]);
      end
    end
    run_txn(1'b1, 1'b0, 32'h000000F0, 32'h0);
    checks++;
    if (bus.d_rdata !== 32'h0000000A) begin
      errors++;
      $display("FAIL load_back: d_rdata=%h, required 0000000a", bus.d_rdata);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a[4];
    exp_t       e;
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33); poke(8'h01, 8'h44);
    e.is_d = 1'b1;
    e.data = 32'h44332211;
    exp_q.push_back(e);
    model_rdata = 32'h44332211;
    bus.d_addr = 32'h000001FE; bus.d_we = 1'b0; bus.d_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (bus.d_ack) bus.d_req = 1'b0;
      if (i <= 4) begin
        checks++;
        if (bus.mem_addr !== exp_a[i-1]) begin
          errors++;
          $display("FAIL wrap_addr: cycle %0d mem_addr=%h, required %h", i, bus.mem_addr,
                   exp_a[i-1]);
        end
      end
    end
    bus.d_req = 1'b0;
  endtask

  task automatic test_rdata_hold();
    poke(8'h60, 8'hDE); poke(8'h61, 8'hAD); poke(8'h62, 8'hBE); poke(8'h63, 8'hEF);
    run_txn(1'b1, 1'b0, 32'h60, 32'h0);
    run_txn(1'b0, 1'b0, 32'h0B, 32'h0);
    checks++;
    if (bus.d_rdata !== 32'hEFBEADDE) begin
      errors++;
      $display("FAIL hold_after_fetch: d_rdata=%h, required efbeadde", bus.d_rdata);
    end
    run_txn(1'b1, 1'b1, 32'h70, 32'h12345678);
    checks++;
    if (bus.d_rdata !== 32'hEFBEADDE) begin
      errors++;
      $display("FAIL hold_after_store: d_rdata=%h, required efbeadde", bus.d_rdata);
    end
    run_txn(1'b1, 1'b0, 32'h70, 32'h0);
    checks++;
    if (bus.d_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL reload: d_rdata=%h, required 12345678", bus.d_rdata);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] exp_b[4];
    exp_b = '{8'h44, 8'h33, 8'hAA, 8'hBB};
    poke(8'h20, 8'h5A); poke(8'h21, 8'h5A); poke(8'h22, 8'hAA); poke(8'h23, 8'hBB);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h11223344;
    @(posedge clk); #1;   // E0: grant
    @(posedge clk); #1;   // E1: byte 0
    @(posedge clk); #1;   // E2: byte 1
    rst = 1'b1;
    bus.d_req = 1'b0;
    model_rdata = 32'h0;
    #1;
    checks++;
    if ({bus.f_ack, bus.d_ack, bus.mem_we, bus.busy} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: f_ack,d_ack,mem_we,busy=%b, required 0000",
               {bus.f_ack, bus.d_ack, bus.mem_we, bus.busy});
    end
    checks++;
    if ({bus.f_ope, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 80'h0) begin
      errors++;
      $display("FAIL midreset_data: f_ope=%h d_rdata=%h mem_addr=%h mem_wdata=%h, required 0",
               bus.f_ope, bus.d_rdata, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b, required 0", bus.busy);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[8'h20 + 8'(k)] !== exp_b[k]) begin
        errors++;
        $display("FAIL midreset_mem: mem[%h]=%h, required %h", 8'h20 + 8'(k),
                 mem[8'h20 + 8'(k)], exp_b[k]);
      end
    end
    run_txn(1'b0, 1'b0, 32'h20, 32'h0);
    checks++;
    if (bus.f_ope !== 32'h4433AABB) begin
      errors++;
      $display("FAIL fetch_after_reset: f_ope=%h, required 4433aabb", bus.f_ope);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fetch();
    test_store_load();
    test_wrap();
    test_rdata_hold();
    test_reset_mid_store();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
